// File: rtl/one_hot_scan_decoder.sv
// -----------------------------------------------------------------------------
// one_hot_scan_decoder
//   Registered N-to-2**N one-hot decoder. It can either decode A directly or
//   auto-scan through every output position. In scan mode each position is held
//   for dreg+1 cycles.
//
// Ports
//   CLK    in   1      clock, rising edge
//   RST    in   1      asynchronous active-high reset
//   EN     in   1      block enable; 0 clears the outputs and scan state
//   MODE   in   1      0 = direct decode, 1 = auto-scan
//   A      in   N      select code (direct) / scan start index (scan entry)
//   LOAD   in   1      latch DWELL into the dwell register
//   DWELL  in   DW     extra hold cycles per scan step
//   I      out  2**N   registered one-hot output (all-zero when not VALID)
//   VALID  out  1      I carries a valid one-hot code
//   WRAP   out  1      one-cycle pulse when the scan returns to index 0
// -----------------------------------------------------------------------------
module one_hot_scan_decoder #(
   parameter int N  = 2,
   parameter int DW = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              MODE,
   input  logic [N-1:0]      A,
   input  logic              LOAD,
   input  logic [DW-1:0]     DWELL,
   output logic [2**N-1:0]   I,
   output logic              VALID,
   output logic              WRAP
);

   localparam int W = 2**N;

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    idx_q, idx_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   dreg_q, dreg_d;
   logic [W-1:0]    i_q, i_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         dreg_q  <= '0;
         i_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dreg_q  <= dreg_d;
         i_q     <= i_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!EN)
         state_d = IDLE;
      else if (!MODE)
         state_d = DIRECT;
      else
         state_d = SCAN;
   end

   // Datapath / output logic
   always_comb begin
      idx_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      // The dwell register is independent of enable, mode and state.
      dreg_d  = LOAD ? DWELL : dreg_q;

      if (EN) begin
         valid_d = 1'b1;
         if (!MODE || state_q != SCAN) begin
            // Direct decode, or scan entry from IDLE/DIRECT: start at A.
            idx_d = A;
         end else if (cnt_q >= dreg_q) begin
            // The >= compare means lowering dreg below cnt mid-step forces an
            // advance, and cnt can never run past dreg.
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
         end else begin
            idx_d = idx_q;
            cnt_d = cnt_q + DW'(1);
         end
      end

      i_d = valid_d ? (W'(1) << idx_d) : '0;
   end

   assign I     = i_q;
   assign VALID = valid_q;
   assign WRAP  = wrap_q;

endmodule

// File: tb/tb_one_hot_scan_decoder.sv
module tb_one_hot_scan_decoder;

   logic       CLK, RST, EN, MODE, LOAD;
   logic [1:0] A;
   logic [0:0] A1;
   logic [7:0] DWELL;
   logic [3:0] I;
   logic       VALID, WRAP;
   logic [1:0] I1;
   logic       VALID1, WRAP1;

   int checks = 0;
   int errors = 0;
   int wraps;

   one_hot_scan_decoder #(.N(2), .DW(8)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .A(A), .LOAD(LOAD),
      .DWELL(DWELL), .I(I), .VALID(VALID), .WRAP(WRAP));

   one_hot_scan_decoder #(.N(1), .DW(8)) dut1 (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .A(A1), .LOAD(LOAD),
      .DWELL(DWELL), .I(I1), .VALID(VALID1), .WRAP(WRAP1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   logic [1:0] av29 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
   logic [3:0] iv29 [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
   logic [3:0] iv30 [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                            4'b0100, 4'b1000, 4'b0001, 4'b0010};
   logic       wv30 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] iv32 [6] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
   logic       wv32 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      RST = 1'b1; EN = 1'b0; MODE = 1'b0; A = '0; A1 = '0; LOAD = 1'b0; DWELL = '0;
      #2;
      chk("reset_I", I, 4'b0000);
      chk("reset_VALID", VALID, 1'b0);
      chk("reset_WRAP", WRAP, 1'b0);
      #10 RST = 1'b0;               // released between edges
      step();
      chk("idle_en0_I", I, 4'b0000);
      chk("idle_en0_VALID", VALID, 1'b0);

      // Direct decode, each code held 4 cycles
      EN = 1'b1; MODE = 1'b0;
      for (int j = 0; j < 4; j++) begin
         A = av29[j];
         for (int r = 0; r < 4; r++) begin
            step();
            chk("direct_I", I, iv29[j]);
            chk("direct_VALID", VALID, 1'b1);
            chk("direct_WRAP", WRAP, 1'b0);
         end
      end

      // Scan with dwell 0 starting at 2
      LOAD = 1'b1; DWELL = 8'd0;
      step();
      LOAD = 1'b0; MODE = 1'b1; A = 2'd2;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("scan0_I", I, iv30[k]);
         chk("scan0_WRAP", WRAP, wv30[k]);
      end

      // Scan with dwell 2 starting at 0: 3 cycles per position
      EN = 1'b0; LOAD = 1'b1; DWELL = 8'd2;
      step();
      chk("en0_I", I, 4'b0000);
      chk("en0_VALID", VALID, 1'b0);
      LOAD = 1'b0; EN = 1'b1; MODE = 1'b1; A = 2'd0;
      wraps = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         chk("scan2_I", I, 4'b0001 << ((k / 3) % 4));
         chk("scan2_WRAP", WRAP, (k > 0 && k % 12 == 0) ? 1 : 0);
         if (WRAP) wraps++;
      end
      chk("scan2_wrap_count", wraps, 2);

      // Lower dwell mid-step: cnt=3 under dwell 5, then load dwell 1
      EN = 1'b0; LOAD = 1'b1; DWELL = 8'd5;
      step();
      LOAD = 1'b0; EN = 1'b1; A = 2'd1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("dwell5_hold_I", I, 4'b0010);
      end
      LOAD = 1'b1; DWELL = 8'd1;
      step();
      chk("dwell_load_edge_I", I, 4'b0010);
      LOAD = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("dwell1_I", I, iv32[k]);
         chk("dwell1_WRAP", WRAP, wv32[k]);
      end

      // A ignored mid-scan, then async reset between edges
      A = 2'd3;
      step();
      chk("scan_ignores_A", I, 4'b0010);
      #2 RST = 1'b1;
      #1;
      chk("async_rst_I", I, 4'b0000);
      chk("async_rst_VALID", VALID, 1'b0);
      chk("async_rst_I_n1", I1, 2'b00);
      #1 RST = 1'b0;
      A1 = 1'b1;
      step();
      chk("post_rst_I", I, 4'b1000);
      chk("post_rst_WRAP", WRAP, 1'b0);
      chk("post_rst_VALID", VALID, 1'b1);
      chk("n1_entry_I", I1, 2'b10);
      chk("n1_entry_WRAP", WRAP1, 1'b0);
      step();
      chk("post_rst_adv_I", I, 4'b0001);
      chk("post_rst_adv_WRAP", WRAP, 1'b1);
      chk("n1_adv_I", I1, 2'b01);
      chk("n1_adv_WRAP", WRAP1, 1'b1);
      step();
      chk("post_rst_adv2_I", I, 4'b0010);
      chk("post_rst_adv2_WRAP", WRAP, 1'b0);
      chk("n1_adv2_I", I1, 2'b10);
      chk("n1_adv2_WRAP", WRAP1, 1'b0);

      // EN dropped for one cycle mid-scan, restart at A=0 without WRAP
      EN = 1'b0;
      step();
      chk("en_drop_I", I, 4'b0000);
      chk("en_drop_VALID", VALID, 1'b0);
      chk("en_drop_WRAP", WRAP, 1'b0);
      chk("n1_en_drop_I", I1, 2'b00);
      EN = 1'b1; A = 2'd0; A1 = 1'b0;
      step();
      chk("reentry_I", I, 4'b0001);
      chk("reentry_WRAP", WRAP, 1'b0);
      chk("n1_reentry_I", I1, 2'b01);
      chk("n1_reentry_WRAP", WRAP1, 1'b0);
      step();
      chk("reentry_adv_I", I, 4'b0010);
      chk("n1_reentry_adv_I", I1, 2'b10);

      // Scan -> direct -> scan
      MODE = 1'b0; A = 2'd2;
      step();
      chk("scan_to_direct_I", I, 4'b0100);
      chk("scan_to_direct_WRAP", WRAP, 1'b0);
      MODE = 1'b1;
      step();
      chk("direct_to_scan_I", I, 4'b0100);
      step();
      chk("direct_to_scan_adv_I", I, 4'b1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
